// File: rtl/mips_cpu_mult_div_pkg.sv
// ----------------------------------------------------------------------------
// mips_cpu_pkg
// Shared definitions for the multiply/divide unit: operation codes as
// produced by the ALU control decoder, the FSM state encoding and the
// default datapath width / iteration count.
// ----------------------------------------------------------------------------
package mips_cpu_pkg;

   localparam int MULDIV_WIDTH = 32;
   // One radix-2 step per operand bit.
   localparam int MULDIV_ITERS = MULDIV_WIDTH;

   typedef enum logic [2:0] {
      OP_DIVU  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_MULT  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_MFHI  = 3'b110,
      OP_MFLO  = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_mult_div_if.sv
// ----------------------------------------------------------------------------
// mips_cpu_mult_div_if
// Request/response bundle between the pipeline and the multiply/divide unit.
//   start  : op valid this cycle
//   op     : 3-bit multiply/divide op code
//   a, b   : rs / rt operands
//   busy   : long operation in flight
//   stall  : request presented while busy; upstream holds op/a/b/start
//   result : HI for MFHI, LO otherwise
//   hi, lo : architectural HI/LO registers
// master = pipeline side, slave = multiply/divide unit.
// ----------------------------------------------------------------------------
interface mips_cpu_mult_div_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             stall;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, stall, result, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, stall, result, hi, lo
   );

endinterface

// File: rtl/mips_cpu_mult_div_iter.sv
// ----------------------------------------------------------------------------
// mips_cpu_muldiv_iter
// Per-cycle datapath of the multiply/divide unit. Works on magnitudes only;
// sign correction is done by the parent.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture operands and mode, clear counter and remainder
//   step       : perform one radix-2 step
//   is_div     : mode captured on load (1 = restoring divide, 0 = shift-add)
//   src_a      : multiplicand / dividend
//   src_b      : multiplier / divisor
//   acc        : multiply: 2*WIDTH product; divide: quotient in low half
//   rem        : divide remainder
//   last       : current step is the final one (counter == WIDTH-1)
// ----------------------------------------------------------------------------
module mips_cpu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   output logic [2*WIDTH-1:0] acc,
   output logic [WIDTH-1:0]   rem,
   output logic               last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] acc_r;
   logic [2*WIDTH-1:0] acc_nxt_s;
   logic [WIDTH-1:0]   rem_r;
   logic [WIDTH-1:0]   rem_nxt_s;
   logic [WIDTH-1:0]   opnd_r;
   logic [CW-1:0]      cnt_r;
   logic               div_mode_r;
   logic [WIDTH:0]     sum_s;
   logic [WIDTH:0]     shifted_s;
   logic [WIDTH:0]     trial_s;

   // One radix-2 step: shift-add for multiply, restore-subtract for divide.
   always_comb begin
      // Multiply: add multiplicand to the upper half when the multiplier LSB
      // (bottom of acc) is set, keeping the carry, then shift right by one.
      sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      // Divide: the dividend sits in acc low half and shifts out MSB-first
      // into the remainder while quotient bits shift in at the bottom.
      shifted_s = {rem_r, acc_r[WIDTH-1]};
      trial_s   = shifted_s - {1'b0, opnd_r};
      acc_nxt_s = acc_r;
      rem_nxt_s = rem_r;
      if (div_mode_r) begin
         acc_nxt_s[WIDTH-1:0] = {acc_r[WIDTH-2:0], ~trial_s[WIDTH]};
         // A borrow means the divisor did not fit: restore.
         rem_nxt_s = trial_s[WIDTH] ? shifted_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
      end else begin
         acc_nxt_s = {sum_s, acc_r[WIDTH-1:1]};
         rem_nxt_s = rem_r;
      end
   end

   // Datapath registers: operand capture on load, advance on step.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r      <= {(2*WIDTH){1'b0}};
         rem_r      <= {WIDTH{1'b0}};
         opnd_r     <= {WIDTH{1'b0}};
         cnt_r      <= {CW{1'b0}};
         div_mode_r <= 1'b0;
      end else if (load) begin
         acc_r      <= is_div ? {{WIDTH{1'b0}}, src_a} : {{WIDTH{1'b0}}, src_b};
         opnd_r     <= is_div ? src_b : src_a;
         rem_r      <= {WIDTH{1'b0}};
         cnt_r      <= {CW{1'b0}};
         div_mode_r <= is_div;
      end else if (step) begin
         acc_r <= acc_nxt_s;
         rem_r <= rem_nxt_s;
         cnt_r <= cnt_r + CW'(1);
      end
   end

   assign acc  = acc_r;
   assign rem  = rem_r;
   assign last = (cnt_r == CW'(WIDTH-1));

endmodule

// File: rtl/mips_cpu_mult_div.sv
// ----------------------------------------------------------------------------
// mips_cpu_mult_div
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH CALC cycles plus one FIX cycle; MTHI/MTLO
// write in one cycle; MFHI/MFLO are read combinationally through result.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (abandons any operation)
//   bus   : request/response bundle (slave side), see mips_cpu_mult_div_if
// ----------------------------------------------------------------------------
module mips_cpu_mult_div
   import mips_cpu_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   mips_cpu_mult_div_if.slave   bus
);

   // Magnitude of a two's-complement value when neg is set; pass-through
   // otherwise. The most negative value maps onto itself, which is the
   // correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                            input logic             neg);
      mag = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   muldiv_state_t      state_r;
   muldiv_state_t      state_nxt_s;
   muldiv_op_t         op_s;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic [WIDTH-1:0]   hi_d_s;
   logic [WIDTH-1:0]   lo_d_s;
   logic               hi_we_s;
   logic               lo_we_s;
   logic               load_s;
   logic               step_s;
   logic               nowrite_s;
   logic               busy_s;
   logic               is_signed_s;
   logic               is_div_s;
   logic               sign_a_s;
   logic               sign_b_s;
   logic [WIDTH-1:0]   src_a_s;
   logic [WIDTH-1:0]   src_b_s;
   logic               neg_main_r;
   logic               neg_rem_r;
   logic               is_div_r;
   logic               nowrite_r;
   logic [2*WIDTH-1:0] acc_s;
   logic [WIDTH-1:0]   rem_s;
   logic               last_s;
   logic [2*WIDTH-1:0] prod_fix_s;
   logic [WIDTH-1:0]   quot_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;

   assign op_s = muldiv_op_t'(bus.op);

   // Operand decode: signedness, mode and magnitudes for the datapath.
   always_comb begin
      is_signed_s = (op_s == OP_MULT) || (op_s == OP_DIV);
      is_div_s    = (op_s == OP_DIV)  || (op_s == OP_DIVU);
      sign_a_s    = is_signed_s & bus.a[WIDTH-1];
      sign_b_s    = is_signed_s & bus.b[WIDTH-1];
      src_a_s     = mag(bus.a, sign_a_s);
      src_b_s     = mag(bus.b, sign_b_s);
   end

   mips_cpu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .reset  (reset),
      .load   (load_s),
      .step   (step_s),
      .is_div (is_div_s),
      .src_a  (src_a_s),
      .src_b  (src_b_s),
      .acc    (acc_s),
      .rem    (rem_s),
      .last   (last_s)
   );

   // Sign correction applied in FIX. Quotient sign is the XOR of operand
   // signs; the remainder follows the dividend.
   always_comb begin
      prod_fix_s = neg_main_r ? (~acc_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_s;
      quot_fix_s = neg_main_r ? (~acc_s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                              : acc_s[WIDTH-1:0];
      rem_fix_s  = neg_rem_r  ? (~rem_s + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_s;
   end

   // FSM next-state and control strobes.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      step_s      = 1'b0;
      nowrite_s   = 1'b0;
      hi_we_s     = 1'b0;
      lo_we_s     = 1'b0;
      hi_d_s      = hi_r;
      lo_d_s      = lo_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               case (op_s)
                  OP_MULT, OP_MULTU: begin
                     load_s      = 1'b1;
                     state_nxt_s = CALC;
                  end
                  OP_DIV, OP_DIVU: begin
                     load_s = 1'b1;
                     // Divide by zero skips the iterations and leaves HI/LO.
                     if (bus.b == {WIDTH{1'b0}}) begin
                        nowrite_s   = 1'b1;
                        state_nxt_s = FIX;
                     end else begin
                        state_nxt_s = CALC;
                     end
                  end
                  OP_MTHI: begin
                     hi_we_s = 1'b1;
                     hi_d_s  = bus.a;
                  end
                  OP_MTLO: begin
                     lo_we_s = 1'b1;
                     lo_d_s  = bus.a;
                  end
                  OP_MFHI, OP_MFLO: begin
                     state_nxt_s = IDLE;
                  end
                  default: begin
                     state_nxt_s = IDLE;
                  end
               endcase
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            step_s = 1'b1;
            if (last_s) begin
               state_nxt_s = FIX;
            end else begin
               state_nxt_s = CALC;
            end
         end
         FIX: begin
            state_nxt_s = IDLE;
            if (!nowrite_r) begin
               hi_we_s = 1'b1;
               lo_we_s = 1'b1;
               if (is_div_r) begin
                  hi_d_s = rem_fix_s;
                  lo_d_s = quot_fix_s;
               end else begin
                  hi_d_s = prod_fix_s[2*WIDTH-1:WIDTH];
                  lo_d_s = prod_fix_s[WIDTH-1:0];
               end
            end else begin
               hi_we_s = 1'b0;
               lo_we_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, HI/LO and per-operation flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         hi_r       <= {WIDTH{1'b0}};
         lo_r       <= {WIDTH{1'b0}};
         neg_main_r <= 1'b0;
         neg_rem_r  <= 1'b0;
         is_div_r   <= 1'b0;
         nowrite_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (hi_we_s) begin
            hi_r <= hi_d_s;
         end
         if (lo_we_s) begin
            lo_r <= lo_d_s;
         end
         if (load_s) begin
            neg_main_r <= sign_a_s ^ sign_b_s;
            neg_rem_r  <= sign_a_s;
            is_div_r   <= is_div_s;
            nowrite_r  <= nowrite_s;
         end
      end
   end

   assign busy_s     = (state_r != IDLE);
   assign bus.busy   = busy_s;
   assign bus.stall  = bus.start & busy_s;
   assign bus.result = (op_s == OP_MFHI) ? hi_r : lo_r;
   assign bus.hi     = hi_r;
   assign bus.lo     = lo_r;

endmodule
